// File: rtl/seq_det_pkg.sv
// Shared constants, state-width helper and transition kinds for the run-sequence detector.
package seq_det_pkg;

   // Symbol value that never advances the detector.
   localparam int HOLD_SYM = 0;

   // Pattern length used when no override is given.
   localparam int DEF_PAT_LEN = 3;

   // Bits needed to hold the states 0..pat_len.
   function automatic int state_w(input int pat_len);
      return $clog2(pat_len + 1);
   endfunction

   // The MATCH state is the state one past the last run index.
   function automatic int match_state(input int pat_len);
      return pat_len;
   endfunction

   // MATCH constant for the default pattern length.
   localparam int DEF_MATCH_ST = DEF_PAT_LEN;

   // Kind of move taken by the detector on one cycle.
   typedef enum logic [2:0] {
      TR_HOLD,
      TR_ADV,
      TR_STAY,
      TR_RESTART,
      TR_IDLE
   } trans_e;

endpackage

// File: rtl/seq_run_detector_sat_counter.sv
// Saturating up-counter with synchronous reset and synchronous clear.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   // Count increments, sticking at all-ones; reset and clear both return to zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/seq_run_detector.sv
// Detects a sequence of symbol runs p[0], p[1], ... p[PAT_LEN-1] on a symbol stream.
// HOLD symbols (0) and invalid cycles leave the state alone; ans is high in MATCH.
// Optional feature macro: SEQDET_MATCH_CNT_EN adds the saturating match_cnt output.
module seq_run_detector
   import seq_det_pkg::*;
#(
   parameter int                          SYM_W   = 2,
   parameter int                          PAT_LEN = 3,
   parameter logic [PAT_LEN*SYM_W-1:0]    DEF_PAT = 6'b11_10_01,
   parameter int                          CNT_W   = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     pat_load,
   input  logic [PAT_LEN*SYM_W-1:0] pat_in,
   input  logic                     in_valid,
   input  logic [SYM_W-1:0]         num,
   output logic                     ans
`ifdef SEQDET_MATCH_CNT_EN
   ,
   output logic [CNT_W-1:0]         match_cnt
`endif
);

   localparam int               ST_W     = state_w(PAT_LEN);
   localparam logic [ST_W-1:0]  ST_IDLE  = '0;
   localparam logic [ST_W-1:0]  ST_MATCH = ST_W'(match_state(PAT_LEN));
   localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(match_state(PAT_LEN) - 1);

   logic [PAT_LEN*SYM_W-1:0] pat_r;
   logic [ST_W-1:0]          state_q;
   logic [ST_W-1:0]          state_d;
   trans_e                   tr;
   logic                     sym_ev;
   logic [SYM_W-1:0]         p_cur;
   logic [SYM_W-1:0]         p_prev;
   logic [SYM_W-1:0]         p_first;

   // A zero pattern entry can never be hit, so such a pattern is undetectable.
   function automatic logic hit(input logic [SYM_W-1:0] s, input logic [SYM_W-1:0] p);
      return (p != SYM_W'(HOLD_SYM)) && (s == p);
   endfunction

   // Pick out the entries relevant to the current state and choose the move.
   always_comb begin
      tr      = TR_HOLD;
      state_d = state_q;
      p_cur   = '0;
      p_prev  = '0;
      p_first = pat_r[SYM_W-1:0];
      sym_ev  = in_valid && (num != SYM_W'(HOLD_SYM));

      // p_cur is the run we are waiting for, p_prev the run we are inside.
      for (int i = 0; i < PAT_LEN; i++) begin
         if (ST_W'(i) == state_q) begin
            p_cur = pat_r[i*SYM_W +: SYM_W];
         end
         if (ST_W'(i + 1) == state_q) begin
            p_prev = pat_r[i*SYM_W +: SYM_W];
         end
      end

      if (pat_load) begin
         tr = TR_IDLE;
      end else if (sym_ev) begin
         if (state_q == ST_IDLE) begin
            tr = hit(num, p_first) ? TR_ADV : TR_IDLE;
         end else if (state_q == ST_MATCH) begin
            if (hit(num, p_prev)) begin
               tr = TR_STAY;
            end else if (hit(num, p_first)) begin
               tr = TR_RESTART;
            end else begin
               tr = TR_IDLE;
            end
         end else begin
            if (hit(num, p_cur)) begin
               tr = TR_ADV;
            end else if (hit(num, p_prev)) begin
               tr = TR_STAY;
            end else if (hit(num, p_first)) begin
               tr = TR_RESTART;
            end else begin
               tr = TR_IDLE;
            end
         end
      end

      case (tr)
         TR_ADV:     state_d = state_q + ST_W'(1);
         TR_RESTART: state_d = ST_W'(1);
         TR_IDLE:    state_d = ST_IDLE;
         default:    state_d = state_q;
      endcase
   end

   // State and pattern registers; a pattern load restarts detection on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pat_r   <= DEF_PAT;
      end else begin
         state_q <= state_d;
         if (pat_load) begin
            pat_r <= pat_in;
         end
      end
   end

   assign ans = (state_q == ST_MATCH);

`ifdef SEQDET_MATCH_CNT_EN
   logic inc_match;

   // Only the completing advance counts; staying in MATCH does not.
   assign inc_match = (tr == TR_ADV) && (state_q == ST_LAST);

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (pat_load),
      .inc   (inc_match),
      .cnt   (match_cnt)
   );
`endif

endmodule

// File: tb/tb_seq_run_detector.sv
// Self-checking bench for seq_run_detector: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model. Honors SEQDET_MATCH_CNT_EN.
module tb_seq_run_detector;

   localparam int SYM_W   = 2;
   localparam int L       = 3;
   localparam int PW      = L * SYM_W;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam logic [PW-1:0] DEF = 6'b11_10_01;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             pat_load = 1'b0;
   logic [PW-1:0]    pat_in = '0;
   logic             in_valid = 1'b0;
   logic [SYM_W-1:0] num = '0;
   logic             ans;
`ifdef SEQDET_MATCH_CNT_EN
   logic [CNT_W-1:0] match_cnt;
`endif

   int total = 0;
   int bad   = 0;
   bit started = 1'b0;

   // Behavioural model state.
   int            m_k   = 0;
   logic [PW-1:0] m_pat = DEF;
   int            m_cnt = 0;

   seq_run_detector #(
      .SYM_W   (SYM_W),
      .PAT_LEN (L),
      .DEF_PAT (DEF),
      .CNT_W   (CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .pat_load  (pat_load),
      .pat_in    (pat_in),
      .in_valid  (in_valid),
      .num       (num),
      .ans       (ans)
`ifdef SEQDET_MATCH_CNT_EN
      ,
      .match_cnt (match_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // Entry i of the model's pattern, or -1 when it is zero (can never be hit).
   function automatic int pe(input int i);
      int v;
      v = int'(m_pat[i*SYM_W +: SYM_W]);
      return (v == 0) ? -1 : v;
   endfunction

   // Next run index according to the run-sequence rules.
   function automatic int next_k(input int k, input bit v, input int s);
      if (!v || s == 0) return k;
      if (k == 0) return (s == pe(0)) ? 1 : 0;
      if (k < L) begin
         if (s == pe(k))   return k + 1;
         if (s == pe(k-1)) return k;
         if (s == pe(0))   return 1;
         return 0;
      end
      if (s == pe(L-1)) return L;
      if (s == pe(0))   return 1;
      return 0;
   endfunction

   // Model advance on each rising edge.
   always @(posedge clk) begin
      if (reset) begin
         m_k   <= 0;
         m_pat <= DEF;
         m_cnt <= 0;
      end else if (pat_load) begin
         m_k   <= 0;
         m_pat <= pat_in;
         m_cnt <= 0;
      end else begin
         m_k <= next_k(m_k, in_valid, int'(num));
         if (m_k == L-1 && next_k(m_k, in_valid, int'(num)) == L && m_cnt < CNT_MAX)
            m_cnt <= m_cnt + 1;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (started) begin
         check("ans", int'(ans), (m_k == L) ? 1 : 0);
`ifdef SEQDET_MATCH_CNT_EN
         check("match_cnt", int'(match_cnt), m_cnt);
`endif
      end
   end

   task automatic step(input bit rst, input bit ld, input logic [PW-1:0] pin,
                       input bit v, input int s);
      @(negedge clk);
      reset    = rst;
      pat_load = ld;
      pat_in   = pin;
      in_valid = v;
      num      = SYM_W'(s);
      @(posedge clk);
      #1;
      reset    = 1'b0;
      pat_load = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic sym(input int s);
      step(1'b0, 1'b0, '0, 1'b1, s);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, '0, 1'b0, 0);
   endtask

   task automatic cnt_lit(input string nm, input int exp);
`ifdef SEQDET_MATCH_CNT_EN
      check(nm, int'(match_cnt), exp);
`endif
   endtask

   initial begin
      do_reset();
      started = 1'b1;
      check("reset_ans", int'(ans), 0);
      cnt_lit("reset_cnt", 0);

      // Default pattern 1,2,3.
      sym(1); sym(2);
      check("r28_pre", int'(ans), 0);
      sym(3);
      check("r28_ans", int'(ans), 1);
      check("r28_model", m_k, 3);
      cnt_lit("r28_cnt", 1);

      // Runs and holds.
      do_reset();
      sym(1); sym(1); sym(0); sym(2); sym(2); sym(0);
      check("r29_pre", int'(ans), 0);
      sym(3);
      check("r29_ans", int'(ans), 1);
      sym(3); sym(0); sym(3); sym(0);
      check("r29_held", int'(ans), 1);
      cnt_lit("r29_cnt", 1);

      // Breaks.
      do_reset();
      sym(1); sym(2); sym(1); sym(2); sym(3);
      check("r30_brk_match", int'(ans), 1);
      do_reset();
      sym(1); sym(3); sym(2); sym(3);
      check("r30_nomatch", int'(ans), 0);
      sym(1); sym(2); sym(3);
      sym(2);
      check("r30_m2_ans", int'(ans), 0);
      check("r30_m2_model", m_k, 0);
      sym(1); sym(2); sym(3);
      check("r30_rematch", int'(ans), 1);
      sym(1);
      check("r30_m1_ans", int'(ans), 0);
      check("r30_m1_model", m_k, 1);

      // Pattern load while in state 2 with a coincident valid symbol.
      do_reset();
      sym(1); sym(2);
      step(1'b0, 1'b1, 6'b11_01_10, 1'b1, 3);
      check("r31_load_ans", int'(ans), 0);
      check("r31_load_model", m_k, 0);
      cnt_lit("r31_load_cnt", 0);
      sym(2); sym(1); sym(3);
      check("r31_newpat", int'(ans), 1);
      cnt_lit("r31_cnt", 1);
      sym(1); sym(2); sym(3);
      check("r31_oldpat", int'(ans), 0);

      // A zero entry makes the pattern undetectable.
      step(1'b0, 1'b1, 6'b11_00_01, 1'b0, 0);
      sym(1); sym(2); sym(3); sym(1); sym(3);
      check("zero_entry", int'(ans), 0);

      // Saturation and reset mid-sequence.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         sym(1); sym(2); sym(3);
      end
      check("r32_ans", int'(ans), 1);
      cnt_lit("r32_sat", 3);
      do_reset();
      sym(1); sym(2);
      do_reset();
      sym(3);
      check("r32_midreset", int'(ans), 0);
      cnt_lit("r32_cnt0", 0);

      // Randomized traffic; the compare process checks every cycle.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         int r;
         logic [PW-1:0] p;
         r = int'($urandom_range(0, 99));
         for (int e = 0; e < L; e++)
            p[e*SYM_W +: SYM_W] = ($urandom_range(0, 9) == 0) ? 2'd0
                                  : SYM_W'($urandom_range(1, 3));
         if (r < 1)
            step(1'b1, 1'b0, p, 1'b1, int'($urandom_range(0, 3)));
         else if (r < 4)
            step(1'b0, 1'b1, p, 1'b1, int'($urandom_range(0, 3)));
         else
            step(1'b0, 1'b0, p, ($urandom_range(0, 9) != 0), int'($urandom_range(0, 3)));
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
